mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers for the CPU execute stage. Accepts the 5-bit ALU control codes for MULT, MULTU, DIV and DIVU and computes the full 2×WIDTH-bit product or the quotient and remainder in a fixed number of cycles. A start/busy/done handshake lets the pipeline stall while it runs, and a flush input aborts it on exceptions. It also carries the architectural HI/LO registers and their direct-write ports (MTHI/MTLO).

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_iter_if.sv | 30 +++
 rtl/mdu_step.sv | 36 +++
 rtl/mdu_iter.sv | 136 +++++++++++++
 tb/tb_mdu_iter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and helpers for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

  // ALU control codes, shared with the ALU decoder
  localparam logic [4:0] MDU_MULT  = 5'b01111;
  localparam logic [4:0] MDU_MULTU = 5'b11111;
  localparam logic [4:0] MDU_DIV   = 5'b01110;
  localparam logic [4:0] MDU_DIVU  = 5'b11110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX
  } mdu_state_e;

  // Iteration counter width for a given operand width
  function automatic int mdu_cnt_w(input int width);
    return $clog2(width);
  endfunction

  function automatic logic mdu_op_valid(input logic [4:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [4:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [4:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Pipeline-side request/result bundle of the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: requester holds off while busy; start is only sampled when busy=0.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  // Execute stage side
  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_zero
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Latency: combinational.
// Backpressure: none.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,      // {partial high, multiplier / dividend-quotient}
  input  logic [WIDTH-1:0]   opnd,     // multiplicand or divisor magnitude
  output logic [2*WIDTH-1:0] acc_nxt,  // next accumulator, quotient bit slot left 0
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  // Single iteration datapath for both modes
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, rem_sh} - {2'b00, opnd};
    acc_nxt = '0;
    q_bit   = 1'b0;
    if (is_div) begin
      // Remainder never exceeds the divisor, so WIDTH bits hold it after the trial subtract.
      q_bit = ~diff[WIDTH+1];
      if (q_bit) acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else       acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_nxt = {sum, acc[WIDTH-1:1]};
      else        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply and divide with architectural HI/LO registers.
// Latency: WIDTH+2 cycles from accepted start to done, independent of operands.
// Backpressure: busy high while running; start ignored until busy drops, flush aborts.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     resetn,
  mdu_iter_if.slave bus
);

  localparam int            CW       = mdu_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, step_acc, prod;
  logic [WIDTH-1:0]   md, a_abs, b_abs, quo, rem, res_hi, res_lo;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               step_q, is_div, is_sgn, neg_q, neg_r, done_q, dz_q;
  logic               accept, fix_fire;

  assign accept   = (state == ST_IDLE) && bus.start && !bus.flush && mdu_op_valid(bus.op);
  assign fix_fire = (state == ST_FIX) && !bus.flush;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush wins from any state
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = ST_PREP;
        ST_PREP: state_nxt = ST_CALC;
        ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (md),
    .acc_nxt (step_acc),
    .q_bit   (step_q)
  );

  // Operand magnitudes and sign-corrected results
  always_comb begin
    a_abs = (is_sgn && acc[WIDTH-1]) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    b_abs = (is_sgn && md[WIDTH-1])  ? -md : md;
    prod  = neg_q ? -acc : acc;
    quo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // With a zero divisor the remainder path already carries |a|, so hi comes back as a.
      res_lo = (md == '0) ? '1 : quo;
      res_hi = rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  // Operand latch, sign preparation and iteration
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      acc    <= '0;
      md     <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          acc    <= {{WIDTH{1'b0}}, bus.a};
          md     <= bus.b;
          is_div <= mdu_is_div(bus.op);
          is_sgn <= mdu_is_signed(bus.op);
        end
        ST_PREP: begin
          neg_q <= is_sgn && (acc[WIDTH-1] ^ md[WIDTH-1]);
          neg_r <= is_sgn && acc[WIDTH-1];
          acc   <= {{WIDTH{1'b0}}, a_abs};
          md    <= b_abs;
          cnt   <= '0;
        end
        ST_CALC: begin
          acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO, done pulse and divide-by-zero flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fix_fire) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
        dz_q   <= is_div && (md == '0);
      end else if (state == ST_IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized ops against an arithmetic model.
// Latency: expects done exactly WIDTH+2 edges after the start edge.
// Backpressure: each op is issued only once busy is low.
module tb_mdu_iter;

  localparam logic [4:0] OP_MULT  = 5'b01111;
  localparam logic [4:0] OP_MULTU = 5'b11111;
  localparam logic [4:0] OP_DIV   = 5'b01110;
  localparam logic [4:0] OP_DIVU  = 5'b11110;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      OP_MULT:  begin p = sx * sy;                 eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = x; ed = 1'b1;
        end else if (o == OP_DIVU) begin
          el = x / y; eh = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  // Issue one op (optionally with a coincident MTLO), track latency/busy, compare against the model.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic we);
    logic [31:0] eh, el;
    logic        ed, busy_ok;
    int          lat;
    model(o, x, y, eh, el, ed);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    bus.lo_we = we;   bus.wdata = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    busy_ok = bus.busy;
    lat = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (bus.done) lat = n;
      else busy_ok = busy_ok & bus.busy;
    end
    check({tag, "_latency"}, lat, 34);
    check({tag, "_busy_span"}, busy_ok, 1'b1);
    check({tag, "_busy_end"}, bus.busy, 1'b0);
    check({tag, "_hi"}, bus.hi, eh);
    check({tag, "_lo"}, bus.lo, el);
    check({tag, "_dz"}, bus.div_zero, ed);
    exp_hi = eh; exp_lo = el; exp_dz = ed;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        seen;
    logic [4:0]  ops[4];
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dz", bus.div_zero, 1'b0);
    #20 resetn = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", bus.lo, 32'h0000_0001);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_lo_const", bus.lo, 32'hFFFF_FFEB);
    run_op("divu_b2b", OP_DIVU, 32'd7, 32'd2, 1'b0);
    check("divu_b2b_lo_const", bus.lo, 32'd3);

    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", bus.lo, 32'h8000_0000);

    run_op("div_zero", OP_DIV, 32'd5, 32'd0, 1'b0);
    check("div_zero_flag_const", bus.div_zero, 1'b1);
    run_op("mult_clr_dz", OP_MULT, 32'd3, 32'd4, 1'b1);

    // Unsupported op code must not start anything
    bus.start = 1'b1; bus.op = 5'b00000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("bad_op_busy", bus.busy, 1'b0);

    // MTHI, then abort a divide with flush; a write during busy is dropped
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi", bus.hi, 32'h1234);
    exp_hi = 32'h1234;
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.hi_we = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | bus.done;
    end
    check("flush_no_done", seen, 1'b0);
    check("flush_hi_kept", bus.hi, exp_hi);
    check("flush_lo_kept", bus.lo, exp_lo);

    // Asynchronous reset in the middle of the iteration
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    check("arst_dz", bus.div_zero, 1'b0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    run_op("post_rst", OP_DIVU, 32'd1000, 32'd7, 1'b0);

    // Randomized ops, some with a coincident MTLO that the result must overwrite
    for (int i = 0; i < 40; i++) begin
      run_op("rand", ops[$urandom_range(0, 3)], pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        check("rand_done_once", bus.done, 1'b0);
      end
    end

    // MTLO while idle
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check("mtlo", bus.lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", bus.hi, exp_hi);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
